// File: rtl/ahb_gpio_pattern_pkg.sv
// Register map and bit positions shared by the AHB GPIO pattern generator.
package ahb_gpio_pattern_pkg;
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PSC    = 3'd1;
  localparam logic [2:0] REG_DATA   = 3'd2;
  localparam logic [2:0] REG_OEB    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_FLUSH = 2;
  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_OVF   = 10;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic       sel;
    logic       write;
    logic [2:0] idx;
    logic       size_ok;
  } ahb_dp_t;
endpackage

// File: rtl/ahb_gpio_pattern_gen_if.sv
// AHB-Lite slave-side signal bundle for the GPIO pattern generator.
interface ahb_gpio_pattern_gen_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport slave  (input  HSEL, HADDR, HWDATA, HREADY, HWRITE, HTRANS, HSIZE,
                  output HRDATA, HREADYOUT);
  modport master (output HSEL, HADDR, HWDATA, HREADY, HWRITE, HTRANS, HSIZE,
                  input  HRDATA, HREADYOUT);
endinterface

// File: rtl/gpio_pat_fifo.sv
// Synchronous pattern FIFO with read-first head and an extra level bit for full detection.
module gpio_pat_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_pop, do_push;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & ~flush & (~full | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/ahb_gpio_pattern_gen.sv
// AHB-Lite slave that streams CPU-pushed 16-bit patterns onto GPIO at a prescaled rate.
module ahb_gpio_pattern_gen
  import ahb_gpio_pattern_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PSC_W = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_gpio_pattern_gen_if.slave bus,
  output logic [15:0]           gpio_out,
  output logic [15:0]           gpio_oeb,
  output logic                  irq
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  ahb_dp_t          dp_q, dp_d;
  logic             en_q, en_d, ie_q, ie_d, ovf_q, ovf_d;
  logic [PSC_W-1:0] psc_q, psc_d, cnt_q, cnt_d;
  logic [15:0]      oeb_q, oeb_d, gpio_q, gpio_d;
  logic [31:0]      rdata;
  logic             wr_en, flush, active, tick, push, ovf_set;
  logic [15:0]      fifo_dout;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_full, fifo_empty;
  logic             unused_bus;

  assign unused_bus = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HWDATA};

  gpio_pat_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push),
    .pop   (tick),
    .flush (flush),
    .din   (bus.HWDATA[15:0]),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Writes land at the end of the data phase, so decode uses the registered address phase.
  always_comb begin
    dp_d = dp_q;
    if (bus.HREADY) begin
      dp_d.sel     = bus.HSEL & bus.HTRANS[1];
      dp_d.write   = bus.HWRITE;
      dp_d.idx     = bus.HADDR[4:2];
      dp_d.size_ok = (bus.HSIZE == HSIZE_WORD);
    end
    wr_en   = dp_q.sel & dp_q.write & dp_q.size_ok;
    flush   = wr_en & (dp_q.idx == REG_CTRL) & bus.HWDATA[CTRL_FLUSH];
    push    = wr_en & (dp_q.idx == REG_DATA);
    active  = en_q & ~fifo_empty;
    tick    = active & (cnt_q == psc_q) & ~flush;
    ovf_set = push & fifo_full & ~tick;

    en_d   = en_q;
    ie_d   = ie_q;
    psc_d  = psc_q;
    oeb_d  = oeb_q;
    ovf_d  = ovf_q;
    cnt_d  = (active & ~tick & ~flush) ? cnt_q + 1'b1 : '0;
    gpio_d = tick ? fifo_dout : gpio_q;
    if (wr_en) begin
      case (dp_q.idx)
        REG_CTRL:   begin en_d = bus.HWDATA[CTRL_EN]; ie_d = bus.HWDATA[CTRL_IE]; end
        REG_PSC:    psc_d = bus.HWDATA[PSC_W-1:0];
        REG_OEB:    oeb_d = bus.HWDATA[15:0];
        REG_STATUS: if (bus.HWDATA[STAT_OVF]) ovf_d = 1'b0;
        default:    ;
      endcase
    end
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_q   <= '0;
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      ovf_q  <= 1'b0;
      psc_q  <= '0;
      cnt_q  <= '0;
      oeb_q  <= 16'hFFFF;
      gpio_q <= '0;
    end else begin
      dp_q   <= dp_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      ovf_q  <= ovf_d;
      psc_q  <= psc_d;
      cnt_q  <= cnt_d;
      oeb_q  <= oeb_d;
      gpio_q <= gpio_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (dp_q.sel && !dp_q.write) begin
      case (dp_q.idx)
        REG_CTRL:   rdata[1:0] = {ie_q, en_q};
        REG_PSC:    rdata[PSC_W-1:0] = psc_q;
        REG_OEB:    rdata[15:0] = oeb_q;
        REG_STATUS: begin
          rdata[LVL_W-1:0]  = fifo_level;
          rdata[STAT_EMPTY] = fifo_empty;
          rdata[STAT_FULL]  = fifo_full;
          rdata[STAT_OVF]   = ovf_q;
        end
        default:    ;
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign gpio_out      = gpio_q;
  assign gpio_oeb      = oeb_q;
  assign irq           = fifo_empty & ie_q;
endmodule

// File: tb/tb_ahb_gpio_pattern_gen.sv
// Randomized bench for ahb_gpio_pattern_gen with a queue-based behavioural reference model.
module tb_ahb_gpio_pattern_gen;
  localparam int DEPTH = 8;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_gpio_pattern_gen_if bus();
  logic [15:0] gpio_out, gpio_oeb;
  logic        irq;

  ahb_gpio_pattern_gen #(.DEPTH(DEPTH), .PSC_W(16)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .bus      (bus),
    .gpio_out (gpio_out),
    .gpio_oeb (gpio_oeb),
    .irq      (irq)
  );

  int n_chk = 0;
  int n_err = 0;
  bit mon_on = 1'b0;
  logic [31:0] pend = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_q[$];
  bit          m_en, m_ie, m_ovf;
  logic [15:0] m_psc, m_cnt, m_oeb, m_gpio;
  bit          m_dv, m_dw, m_dok;
  int          m_di;

  task automatic mdl_reset();
    m_q.delete();
    m_en = 0; m_ie = 0; m_ovf = 0;
    m_psc = 0; m_cnt = 0; m_oeb = 16'hFFFF; m_gpio = 0;
    m_dv = 0; m_dw = 0; m_dok = 0; m_di = 0;
  endtask

  function automatic logic [31:0] exp_rd(input int idx);
    case (idx)
      0: return {30'd0, m_ie, m_en};
      1: return {16'd0, m_psc};
      3: return {16'd0, m_oeb};
      4: return 32'(m_q.size()) | (m_q.size() == 0 ? 32'h100 : 0)
                | (m_q.size() == DEPTH ? 32'h200 : 0) | (m_ovf ? 32'h400 : 0);
      default: return 32'd0;
    endcase
  endfunction

  task automatic mdl_step();
    bit wr, fl, act, tk, set_ovf;
    logic [31:0] wd;
    int n;
    if (!HRESETn) begin mdl_reset(); return; end
    wd  = bus.HWDATA;
    wr  = m_dv && m_dw && m_dok;
    fl  = wr && m_di == 0 && wd[2];
    n   = m_q.size();
    act = m_en && n != 0;
    tk  = act && m_cnt == m_psc && !fl;
    set_ovf = 0;
    if (tk) m_gpio = m_q.pop_front();
    if (wr && m_di == 2) begin
      if (n < DEPTH || tk) m_q.push_back(wd[15:0]);
      else set_ovf = 1;
    end
    if (fl) m_q.delete();
    m_cnt = (act && !tk && !fl) ? m_cnt + 16'd1 : 16'd0;
    if (wr) begin
      case (m_di)
        0: begin m_en = wd[0]; m_ie = wd[1]; end
        1: m_psc = wd[15:0];
        3: m_oeb = wd[15:0];
        4: if (wd[10]) m_ovf = 0;
        default: ;
      endcase
    end
    if (set_ovf) m_ovf = 1;
    if (bus.HREADY) begin
      m_dv  = bus.HSEL && bus.HTRANS[1];
      m_dw  = bus.HWRITE;
      m_di  = int'(bus.HADDR[4:2]);
      m_dok = (bus.HSIZE == 3'b010);
    end
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge HCLK or negedge HRESETn);
      mdl_step();
    end
  end

  // Continuous comparison of every observable output against the model.
  initial forever begin
    @(negedge HCLK);
    if (HRESETn && mon_on) begin
      chk("gpio_out", 32'(gpio_out), 32'(m_gpio));
      chk("gpio_oeb", 32'(gpio_oeb), 32'(m_oeb));
      chk("irq", 32'(irq), 32'(m_ie && m_q.size() == 0));
      chk("hreadyout", 32'(bus.HREADYOUT), 32'd1);
      if (m_dv && !m_dw) chk("hrdata", bus.HRDATA, exp_rd(m_di));
    end
  end

  // ---------------- bus driver ----------------
  task automatic cyc(input logic sel, input logic [1:0] trans, input logic wr,
                     input int idx, input logic [2:0] size);
    logic [31:0] a;
    a = $urandom;
    a[4:2] = 3'(idx);
    a[1:0] = 2'b00;
    @(negedge HCLK);
    bus.HSEL = sel; bus.HTRANS = trans; bus.HWRITE = wr;
    bus.HADDR = a; bus.HSIZE = size; bus.HWDATA = pend;
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] data, input logic [2:0] size = 3'b010);
    cyc(1'b1, 2'b10, 1'b1, idx, size);
    pend = data;
  endtask

  task automatic rd_reg(input int idx);
    cyc(1'b1, 2'b10, 1'b0, idx, 3'b010);
    pend = $urandom;
  endtask

  task automatic idle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 2'b00, 1'b0, 0, 3'b010);
      pend = $urandom;
    end
  endtask

  task automatic rd_expect(input string tag, input int idx, input logic [31:0] exp);
    rd_reg(idx);
    idle();
    chk(tag, bus.HRDATA, exp);
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_gpio_oeb", 32'(gpio_oeb), 32'hFFFF);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    @(negedge HCLK);
    bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0; pend = 0;
    HRESETn = 1'b1;
  endtask

  initial begin
    bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0; bus.HADDR = 0;
    bus.HSIZE = 3'b010; bus.HWDATA = 0; bus.HREADY = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    do_reset();
    mon_on = 1'b1;
    rd_expect("rst_status", 4, 32'h100);
    rd_expect("rst_ctrl", 0, 32'h0);

    // PSC=3 two-pattern stream with interrupt on drain
    wr_reg(1, 3);
    wr_reg(2, 32'h1111);
    wr_reg(2, 32'h2222);
    wr_reg(0, 3);
    idle();
    idle(5);
    chk("stream_first", 32'(gpio_out), 32'h1111);
    idle(4);
    chk("stream_second", 32'(gpio_out), 32'h2222);
    chk("stream_irq", 32'(irq), 32'h1);
    idle(6);
    chk("stream_hold", 32'(gpio_out), 32'h2222);

    // overflow and W1C
    wr_reg(0, 0);
    for (int i = 0; i < 9; i++) wr_reg(2, 32'h100 + i);
    idle();
    rd_expect("ovf_status", 4, 32'h608);
    wr_reg(4, 32'h400);
    idle();
    rd_expect("ovf_clear", 4, 32'h208);

    // push while full in a tick cycle
    wr_reg(1, 0);
    wr_reg(0, 1);
    wr_reg(2, 32'hABCD);
    rd_reg(4);
    idle();
    chk("full_push_tick", bus.HRDATA, 32'h208);
    idle(12);
    chk("full_push_last", 32'(gpio_out), 32'hABCD);

    // flush
    wr_reg(0, 0);
    wr_reg(1, 100);
    for (int i = 0; i < 5; i++) wr_reg(2, 32'h5000 + i);
    wr_reg(0, 1);
    idle();
    rd_expect("pre_flush", 4, 32'h5);
    wr_reg(0, 5);
    idle();
    rd_expect("post_flush", 4, 32'h100);
    chk("flush_gpio", 32'(gpio_out), 32'hABCD);
    idle(10);
    chk("flush_nopop", 32'(gpio_out), 32'hABCD);
    rd_expect("flush_selfclr", 0, 32'h1);

    // byte write ignored, OEB, then reset mid-stream
    wr_reg(1, 32'h55, 3'b000);
    idle();
    rd_expect("byte_psc", 1, 32'd100);
    wr_reg(3, 32'h00FF);
    idle(2);
    chk("oeb_write", 32'(gpio_oeb), 32'h00FF);
    wr_reg(1, 1);
    for (int i = 0; i < 4; i++) wr_reg(2, 32'hC000 + i);
    wr_reg(0, 3);
    idle(4);
    do_reset();
    rd_expect("reset_status", 4, 32'h100);
    rd_expect("reset_psc", 1, 32'h0);

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 30)      wr_reg(2, $urandom);
      else if (op < 40) wr_reg(0, {29'd0, ($urandom_range(0, 7) == 0), 2'($urandom)});
      else if (op < 46) wr_reg(1, $urandom_range(0, 3));
      else if (op < 50) wr_reg(3, $urandom);
      else if (op < 54) wr_reg(4, $urandom);
      else if (op < 70) rd_reg($urandom_range(0, 7));
      else if (op < 74) wr_reg($urandom_range(0, 4), $urandom, 3'($urandom_range(0, 1)));
      else if (op < 78) cyc(1'b1, 2'($urandom_range(0, 1)), 1'($urandom), $urandom_range(0, 4), 3'b010);
      else              idle();
    end
    idle(4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
